aes_cipher_iter: RTL and testbench

- Iterative AES encryption core (FIPS-197) for AES-128/192/256, selected by NR/NK.
- Companion of the existing iterative decipher: it consumes the same pre-expanded key bus and the same state byte ordering.
- It computes one round per clock and adds a start/busy/done handshake.
- Sits between the key-expansion block and the block-mode/datapath controller.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_enc_round.sv | 48 ++++
 rtl/aes_cipher_iter.sv | 108 ++++++++++
 tb/tb_aes_cipher_iter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES definitions for the iterative cipher (and its decipher twin).
//   Contents:
//     NB          - number of 32-bit columns in the AES state (always 4)
//     aes_fsm_t   - round-engine FSM state type, with IDLE / RUN encodings
//     aes_sbox()  - forward FIPS-197 S-box lookup
//     xtime()     - multiply by x in GF(2^8), reduction polynomial 0x11B
//     byte_msb()  - MSB bit position of state byte (row, col) in a 128-bit
//                   bus, with byte 0 at [127:120] and column-major ordering
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NB = 4;

    typedef logic [0:0] aes_fsm_t;
    localparam aes_fsm_t IDLE = 1'b0;
    localparam aes_fsm_t RUN  = 1'b1;

    // Forward S-box, entry 0x00 in the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // State byte (row, col) is byte index NB*col+row of the block.
    function automatic int byte_msb(input int row, input int col);
        return 127 - 8 * (NB * col + row);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// -----------------------------------------------------------------------------
// aes_enc_round
//   One combinational AES encryption round:
//     state_out = AddRoundKey(MixColumns?(ShiftRows(SubBytes(state_in))))
//   MixColumns is bypassed when last_round is high.
//   Ports:
//     state_in   [127:0] in   current state (byte 0 at [127:120], column-major)
//     round_key  [127:0] in   round key, same byte ordering
//     last_round         in   1 = final round, skip MixColumns
//     state_out  [127:0] out  next state
// -----------------------------------------------------------------------------
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    // Byte-indexed intermediates, index = NB*col + row.
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_col
            for (gj = 0; gj < 4; gj++) begin : g_row
                assign sb[NB*gi+gj] = aes_sbox(state_in[byte_msb(gj, gi) -: 8]);

                // Row r rotates left by r columns.
                assign sr[NB*gi+gj] = sb[NB*((gi+gj)%NB)+gj];

                // Circulant row (2,3,1,1): 3*a = xtime(a)^a.
                assign mc[NB*gi+gj] = xtime(sr[NB*gi+gj])
                                    ^ xtime(sr[NB*gi+(gj+1)%4]) ^ sr[NB*gi+(gj+1)%4]
                                    ^ sr[NB*gi+(gj+2)%4]
                                    ^ sr[NB*gi+(gj+3)%4];

                assign state_out[byte_msb(gj, gi) -: 8] =
                    (last_round ? sr[NB*gi+gj] : mc[NB*gi+gj])
                    ^ round_key[byte_msb(gj, gi) -: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter
//   Iterative AES-128/192/256 encryption, one round per clock.
//   Ports:
//     clk                         in   clock
//     reset                       in   asynchronous active-high reset
//     start                       in   one-cycle request, taken only when idle
//     input_bytes  [127:0]        in   plaintext, sampled at the accepted start
//     ExpandedKeys [128*(NR+1)-1:0] in round keys, round 0 in the MSBs; must
//                                      stay stable from start until done
//     busy                        out  rounds in progress
//     done                        out  one-cycle pulse when out is updated
//     out          [127:0]        out  ciphertext, held until the next result
//   A start is accepted NR cycles before its done pulse; since the FSM is back
//   in IDLE during the done cycle, a start in that cycle is taken at once.
// -----------------------------------------------------------------------------
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int NK = 4
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [127:0]            input_bytes,
    input  logic [128*(NR+1)-1:0]   ExpandedKeys,
    output logic                    busy,
    output logic                    done,
    output logic [127:0]            out
);

    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    // NK only documents the key size; flag an inconsistent pairing early.
    generate
        if (NR != NK + 6) begin : g_cfg_check
            $error("aes_cipher_iter: NR=%0d does not match NK=%0d", NR, NK);
        end
    endgenerate

    logic [127:0]  round_keys [NR+1];

    genvar gi;
    generate
        for (gi = 0; gi <= NR; gi++) begin : g_key
            assign round_keys[gi] = ExpandedKeys[128*(NR+1)-1-128*gi -: 128];
        end
    endgenerate

    aes_fsm_t      fsm_reg;
    logic [RW-1:0] round_reg;
    logic [127:0]  state_reg;
    logic [127:0]  round_out;
    logic          last_round;

    assign last_round = (round_reg == LAST_ROUND);

    // Single shared round datapath; the key is picked by the round counter.
    aes_enc_round u_round (
        .state_in   (state_reg),
        .round_key  (round_keys[round_reg]),
        .last_round (last_round),
        .state_out  (round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_reg   <= IDLE;
            round_reg <= '0;
            state_reg <= '0;
            out       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= input_bytes ^ round_keys[0];
                        round_reg <= RW'(1);
                        fsm_reg   <= RUN;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_round) begin
                        // Counter holds at NR in IDLE; it reloads on start.
                        out     <= round_out;
                        fsm_reg <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_reg <= round_out;
                        round_reg <= round_reg + RW'(1);
                    end
                end
                default: begin
                    fsm_reg <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_iter
//   Drives an AES-128 (NR=10) and an AES-256 (NR=14) instance. Expected
//   ciphertexts come from known-answer constants or from a byte-level AES
//   model (S-box derived from GF(2^8) inverses, generic key schedule and
//   matrix MixColumns). A monitor retires expectations on each done pulse.
// -----------------------------------------------------------------------------
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           start10, start14;
    logic [127:0]   pt10, pt14, out10, out14;
    logic [1919:0]  bus10_full, bus14;
    logic [1407:0]  keys10;
    logic           busy10, done10, busy14, done14;

    assign keys10 = bus10_full[1919 -: 1408];

    aes_cipher_iter #(.NR(10), .NK(4)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .input_bytes(pt10),
        .ExpandedKeys(keys10), .busy(busy10), .done(done10), .out(out10)
    );

    aes_cipher_iter #(.NR(14), .NK(8)) dut14 (
        .clk(clk), .reset(reset), .start(start14), .input_bytes(pt14),
        .ExpandedKeys(bus14), .busy(busy14), .done(done14), .out(out14)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [127:0] ct;
        int           cyc;
    } exp_t;
    exp_t q10[$];
    exp_t q14[$];

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key left-aligned in 256 bits; returns round keys with round 0 at the top.
    function automatic logic [1919:0] key_expand(input logic [255:0] key,
                                                  input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] bus = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr+1); i++) bus[1919-32*i -: 32] = w[i];
        return bus;
    endfunction

    function automatic logic [127:0] encrypt_ref(input logic [127:0] pt,
                                                  input logic [1919:0] bus,
                                                  input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] res;
        rk = bus[1919 -: 128];
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[127-8*k -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox_t[s[k]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[4*c+rr] = t[4*((c+rr)%4)+rr];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int rr = 0; rr < 4; rr++) t[rr] = s[4*c+rr];
                    for (int rr = 0; rr < 4; rr++)
                        s[4*c+rr] = gmul(8'h02, t[rr]) ^ gmul(8'h03, t[(rr+1)%4])
                                  ^ t[(rr+2)%4] ^ t[(rr+3)%4];
                end
            end
            rk = bus[1919-128*r -: 128];
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done10 === 1'b1) begin
            if (q10.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dut10_spurious_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = q10.pop_front();
                chk("dut10_ct", out10, e.ct);
                chk("dut10_done_cycle", 128'(cyc), 128'(e.cyc));
                $display("dut10 block retired at cycle %0d ct=%h", cyc, out10);
            end
        end
        if (done14 === 1'b1) begin
            if (q14.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dut14_spurious_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = q14.pop_front();
                chk("dut14_ct", out14, e.ct);
                chk("dut14_done_cycle", 128'(cyc), 128'(e.cyc));
                $display("dut14 block retired at cycle %0d ct=%h", cyc, out14);
            end
        end
    end

    // Must be called between clock edges; returns 1 time unit after the
    // edge that samples start.
    task automatic issue(input int which, input logic [127:0] pt, input logic [127:0] ct);
        exp_t e;
        e.ct = ct;
        if (which == 10) begin
            e.cyc = cyc + 1 + 10;
            start10 = 1'b1; pt10 = pt; q10.push_back(e);
        end else begin
            e.cyc = cyc + 1 + 14;
            start14 = 1'b1; pt14 = pt; q14.push_back(e);
        end
        @(posedge clk); #1;
        if (which == 10) start10 = 1'b0; else start14 = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or after the budget).
    task automatic wait_done(input int which, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((which == 10) ? done10 : done14) !== 1'b1 && n < budget);
        if (((which == 10) ? done10 : done14) !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL dut%0d_done_timeout: no done after %0d cycles, required within %0d",
                     which, n, budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] KAT1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KAT1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KAT_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KAT3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [127:0] p;
        logic [127:0] q;
        reset = 1'b1;
        start10 = 1'b0; start14 = 1'b0;
        pt10 = '0; pt14 = '0;
        init_sbox();
        bus10_full = key_expand({KAT1_KEY, 128'h0}, 4, 10);
        bus14      = key_expand(KAT3_KEY, 8, 14);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out10", out10, '0);
        chk("rst_busy10", 128'(busy10), '0);
        chk("rst_done10", 128'(done10), '0);
        chk("rst_out14", out14, '0);
        chk("rst_busy14", 128'(busy14), '0);
        chk("rst_done14", 128'(done14), '0);
        reset = 1'b0;

        // FIPS-197 Appendix B vector, with busy/done timing
        @(posedge clk); #1;
        issue(10, KAT1_PT, KAT1_CT);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("kat1_busy_run", 128'(busy10), 128'(1));
            chk("kat1_done_early", 128'(done10), '0);
        end
        @(negedge clk);
        chk("kat1_done_pulse", 128'(done10), 128'(1));
        chk("kat1_busy_after", 128'(busy10), '0);
        @(negedge clk);
        chk("kat1_done_width", 128'(done10), '0);

        // Appendix C.1 vector, then a back-to-back block started in the done cycle
        bus10_full = key_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        @(posedge clk); #1;
        issue(10, KAT_PT, KAT2_CT);
        wait_done(10, 12);
        p = rand128();
        issue(10, p, encrypt_ref(p, bus10_full, 10));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("b2b_out_held", out10, KAT2_CT);
        end
        wait_done(10, 12);

        // Appendix C.3 vector on the 14-round instance, plus a modelled block
        @(posedge clk); #1;
        issue(14, KAT_PT, KAT3_CT);
        wait_done(14, 16);
        p = rand128();
        issue(14, p, encrypt_ref(p, bus14, 14));
        wait_done(14, 16);

        // Start pulsed during a run is ignored
        bus10_full = key_expand({rand128(), 128'h0}, 4, 10);
        p = rand128();
        q = rand128();
        @(posedge clk); #1;
        issue(10, p, encrypt_ref(p, bus10_full, 10));
        @(posedge clk); #1;
        @(posedge clk); #1;
        start10 = 1'b1; pt10 = q;
        @(posedge clk); #1;
        start10 = 1'b0;
        chk("ignored_start_busy", 128'(busy10), 128'(1));
        wait_done(10, 12);
        repeat (3) begin
            @(negedge clk);
            chk("ignored_start_no_done", 128'(done10), '0);
        end

        // Asynchronous reset mid-run
        p = rand128();
        @(posedge clk); #1;
        issue(10, p, encrypt_ref(p, bus10_full, 10));
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        q10.delete();
        chk("midrst_out", out10, '0);
        chk("midrst_busy", 128'(busy10), '0);
        chk("midrst_done", 128'(done10), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_idle_busy", 128'(busy10), '0);
        bus10_full = key_expand({KAT1_KEY, 128'h0}, 4, 10);
        @(posedge clk); #1;
        issue(10, KAT1_PT, KAT1_CT);
        wait_done(10, 12);

        // Output held with no start while input_bytes wanders
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            pt10 = rand128();
            @(negedge clk);
            chk("hold_out", out10, KAT1_CT);
            chk("hold_done", 128'(done10), '0);
        end

        // Randomized blocks on both instances concurrently
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    logic [127:0] rp;
                    bus10_full = key_expand({rand128(), 128'h0}, 4, 10);
                    rp = rand128();
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    @(posedge clk); #1;
                    issue(10, rp, encrypt_ref(rp, bus10_full, 10));
                    wait_done(10, 12);
                end
            end
            begin
                for (int b = 0; b < 6; b++) begin
                    logic [127:0] rp;
                    bus14 = key_expand({rand128(), rand128()}, 8, 14);
                    rp = rand128();
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    @(posedge clk); #1;
                    issue(14, rp, encrypt_ref(rp, bus14, 14));
                    wait_done(14, 16);
                end
            end
        join

        repeat (5) @(negedge clk);
        chk("q10_drained", 128'(q10.size()), '0);
        chk("q14_drained", 128'(q14.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
